// File: rtl/multicycle_control.sv
// Multi-cycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a memory ready handshake,
// datapath strobes, a sticky illegal-opcode trap and a retired-instruction counter.
//
// state  | meaning
// FETCH  | request instruction, load IR and PC+1 on mem_ready
// DECODE | latch opcode; JMP retires here, illegal opcodes trap
// EXEC   | ALU operation; BEQ retires here
// MEM    | data memory access, held until mem_ready
// WB     | register file writeback, instruction retires
// TRAP   | illegal opcode seen, all strobes idle until rst
module multicycle_control #(
    parameter int OPCODE_W = 4,
    parameter int ALU_OP_W = 2,
    parameter int RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic [2:0]          state_o,
    output logic                imem_req,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                alu_src,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                instr_done,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retire_count
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_OR  = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_LW  = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_SW  = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_BEQ = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(7);

    state_t                state_q, state_d;
    logic [OPCODE_W-1:0]   opc_q, opc_d;
    logic                  illegal_q, illegal_d;
    logic [RETIRE_W-1:0]   retire_q;

    logic is_rtype, is_lw, is_sw, is_beq;

    assign is_rtype = (opc_q <= OP_OR);
    assign is_lw    = (opc_q == OP_LW);
    assign is_sw    = (opc_q == OP_SW);
    assign is_beq   = (opc_q == OP_BEQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            opc_q     <= '0;
            illegal_q <= 1'b0;
            retire_q  <= '0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            illegal_q <= illegal_d;
            if (instr_done) retire_q <= retire_q + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        opc_d      = opc_q;
        illegal_d  = illegal_q;
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        alu_op     = '0;
        instr_done = 1'b0;
        // Strobes are suppressed while rst is high so an aborted instruction never retires or writes.
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    opc_d = opcode;
                    if (opcode > OP_JMP) begin
                        state_d   = S_TRAP;
                        illegal_d = 1'b1;
                    end else if (opcode == OP_JMP) begin
                        pc_write   = 1'b1;
                        pc_src     = 2'b10;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_rtype) begin
                        alu_op[1:0] = opc_q[1:0];
                        reg_dst     = 1'b1;
                        state_d     = S_WB;
                    end else if (is_lw || is_sw) begin
                        alu_src = 1'b1;
                        state_d = S_MEM;
                    end else if (is_beq) begin
                        alu_op[1:0] = 2'b01;
                        pc_write    = zero;
                        pc_src      = 2'b01;
                        instr_done  = 1'b1;
                        state_d     = S_FETCH;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = is_sw;
                    alu_src  = 1'b1;
                    if (mem_ready) begin
                        if (is_sw) begin
                            instr_done = 1'b1;
                            state_d    = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = is_lw;
                    reg_dst    = is_rtype;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
                S_TRAP: begin
                    state_d = S_TRAP;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    assign state_o      = state_q;
    assign illegal      = illegal_q & ~rst;
    assign retire_count = retire_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a table of per-cycle vectors plus hand-written
// sequences for the trap, reset-during-MEM abort and retire counter wrap.
module tb_multicycle_control;

    logic        clk;
    logic        rst;
    logic [3:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic [2:0]  state_o;
    logic        imem_req, ir_write, pc_write;
    logic [1:0]  pc_src;
    logic        dmem_req, dmem_we, reg_write, mem_to_reg, reg_dst, alu_src;
    logic [1:0]  alu_op;
    logic        instr_done, illegal;
    logic [3:0]  retire_count;

    int n_checks = 0;
    int n_errors = 0;

    multicycle_control #(.OPCODE_W(4), .ALU_OP_W(2), .RETIRE_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .state_o(state_o), .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .alu_src(alu_src), .alu_op(alu_op),
        .instr_done(instr_done), .illegal(illegal), .retire_count(retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word: {imem_req, ir_write, pc_write, pc_src[1:0], dmem_req, dmem_we, reg_write,
    //                mem_to_reg, reg_dst, alu_src, alu_op[1:0], instr_done, illegal}
    localparam logic [14:0] NONE   = 15'b0_0_0_00_0_0_0_0_0_0_00_0_0;
    localparam logic [14:0] IMEM   = 15'b1_0_0_00_0_0_0_0_0_0_00_0_0;
    localparam logic [14:0] F_ACK  = 15'b1_1_1_00_0_0_0_0_0_0_00_0_0;
    localparam logic [14:0] EX_ADD = 15'b0_0_0_00_0_0_0_0_1_0_00_0_0;
    localparam logic [14:0] EX_OR  = 15'b0_0_0_00_0_0_0_0_1_0_11_0_0;
    localparam logic [14:0] WB_R   = 15'b0_0_0_00_0_0_1_0_1_0_00_1_0;
    localparam logic [14:0] EX_LS  = 15'b0_0_0_00_0_0_0_0_0_1_00_0_0;
    localparam logic [14:0] MEM_LW = 15'b0_0_0_00_1_0_0_0_0_1_00_0_0;
    localparam logic [14:0] WB_LW  = 15'b0_0_0_00_0_0_1_1_0_0_00_1_0;
    localparam logic [14:0] BEQ_T  = 15'b0_0_1_01_0_0_0_0_0_0_01_1_0;
    localparam logic [14:0] BEQ_N  = 15'b0_0_0_01_0_0_0_0_0_0_01_1_0;
    localparam logic [14:0] SW_WT  = 15'b0_0_0_00_1_1_0_0_0_1_00_0_0;
    localparam logic [14:0] SW_RDY = 15'b0_0_0_00_1_1_0_0_0_1_00_1_0;
    localparam logic [14:0] JMP    = 15'b0_0_1_10_0_0_0_0_0_0_00_1_0;
    localparam logic [14:0] ILL    = 15'b0_0_0_00_0_0_0_0_0_0_00_0_1;

    typedef struct {
        logic        rst;
        logic [3:0]  opc;
        logic        zero;
        logic        mr;
        logic [2:0]  st;
        logic [14:0] ctl;
        logic [3:0]  rc;
    } vec_t;

    vec_t tbl[$];

    // Drive inputs just after the falling edge, compare once they settle, well before the rising edge.
    task automatic chk(input logic r, input logic [3:0] opc, input logic z, input logic mr,
                       input logic [2:0] st, input logic [14:0] ctl, input logic [3:0] rc,
                       input string name);
        logic [14:0] act;
        @(negedge clk);
        rst = r; opcode = opc; zero = z; mem_ready = mr;
        #1;
        act = {imem_req, ir_write, pc_write, pc_src, dmem_req, dmem_we, reg_write,
               mem_to_reg, reg_dst, alu_src, alu_op, instr_done, illegal};
        n_checks++;
        if (act !== ctl || state_o !== st || retire_count !== rc) begin
            n_errors++;
            $display("FAIL %s: got state=%0d ctl=%b rc=%0d, expected state=%0d ctl=%b rc=%0d",
                     name, state_o, act, retire_count, st, ctl, rc);
        end
    endtask

    initial begin
        rst = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;

        tbl.push_back('{1'b1, 4'd0, 1'b0, 1'b0, 3'd0, NONE,   4'd0});
        tbl.push_back('{1'b1, 4'd0, 1'b0, 1'b1, 3'd0, NONE,   4'd0});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 1'b0, 3'd0, IMEM,   4'd0});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 3'd0, F_ACK,  4'd0});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 3'd1, NONE,   4'd0});
        tbl.push_back('{1'b0, 4'd7, 1'b0, 1'b1, 3'd2, EX_ADD, 4'd0});
        tbl.push_back('{1'b0, 4'd7, 1'b0, 1'b1, 3'd4, WB_R,   4'd0});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 3'd0, F_ACK,  4'd1});
        tbl.push_back('{1'b0, 4'd4, 1'b0, 1'b0, 3'd1, NONE,   4'd1});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 3'd2, EX_LS,  4'd1});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 1'b0, 3'd3, MEM_LW, 4'd1});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 1'b0, 3'd3, MEM_LW, 4'd1});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 1'b0, 3'd3, MEM_LW, 4'd1});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 3'd3, MEM_LW, 4'd1});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 1'b0, 3'd4, WB_LW,  4'd1});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 3'd0, F_ACK,  4'd2});
        tbl.push_back('{1'b0, 4'd6, 1'b0, 1'b0, 3'd1, NONE,   4'd2});
        tbl.push_back('{1'b0, 4'd0, 1'b1, 1'b0, 3'd2, BEQ_T,  4'd2});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 3'd0, F_ACK,  4'd3});
        tbl.push_back('{1'b0, 4'd6, 1'b1, 1'b0, 3'd1, NONE,   4'd3});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 1'b0, 3'd2, BEQ_N,  4'd3});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 3'd0, F_ACK,  4'd4});
        tbl.push_back('{1'b0, 4'd5, 1'b0, 1'b0, 3'd1, NONE,   4'd4});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 1'b0, 3'd2, EX_LS,  4'd4});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 3'd3, SW_RDY, 4'd4});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 3'd0, F_ACK,  4'd5});
        tbl.push_back('{1'b0, 4'd7, 1'b0, 1'b0, 3'd1, JMP,    4'd5});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 3'd0, F_ACK,  4'd6});
        tbl.push_back('{1'b0, 4'd3, 1'b0, 1'b0, 3'd1, NONE,   4'd6});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 1'b0, 3'd2, EX_OR,  4'd6});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 1'b0, 3'd4, WB_R,   4'd6});
        tbl.push_back('{1'b0, 4'd0, 1'b0, 1'b0, 3'd0, IMEM,   4'd7});

        foreach (tbl[i])
            chk(tbl[i].rst, tbl[i].opc, tbl[i].zero, tbl[i].mr, tbl[i].st, tbl[i].ctl, tbl[i].rc,
                $sformatf("vec%0d", i));

        // Illegal opcode traps and stays idle regardless of inputs until reset.
        chk(1'b0, 4'd0, 1'b0, 1'b1, 3'd0, F_ACK, 4'd7, "trap_fetch");
        chk(1'b0, 4'd8, 1'b0, 1'b0, 3'd1, NONE,  4'd7, "trap_decode");
        for (int i = 0; i < 20; i++)
            chk(1'b0, 4'($urandom), 1'($urandom), 1'b1, 3'd5, ILL, 4'd7, $sformatf("trap_hold%0d", i));
        chk(1'b1, 4'd0, 1'b0, 1'b1, 3'd5, NONE, 4'd7, "trap_rst");
        chk(1'b0, 4'd0, 1'b0, 1'b0, 3'd0, IMEM, 4'd0, "trap_cleared");

        // Reset while a SW waits in MEM with mem_ready arriving: no write, no retire.
        chk(1'b0, 4'd0, 1'b0, 1'b1, 3'd0, F_ACK, 4'd0, "abort_fetch");
        chk(1'b0, 4'd5, 1'b0, 1'b0, 3'd1, NONE,  4'd0, "abort_decode");
        chk(1'b0, 4'd0, 1'b0, 1'b0, 3'd2, EX_LS, 4'd0, "abort_exec");
        chk(1'b0, 4'd0, 1'b0, 1'b0, 3'd3, SW_WT, 4'd0, "abort_mem_wait");
        chk(1'b1, 4'd0, 1'b0, 1'b1, 3'd3, NONE,  4'd0, "abort_rst");
        chk(1'b0, 4'd0, 1'b0, 1'b0, 3'd0, IMEM,  4'd0, "abort_after");

        // Sixteen JMPs wrap the 4-bit retire counter back to zero.
        for (int i = 0; i < 16; i++) begin
            chk(1'b0, 4'd0, 1'b0, 1'b1, 3'd0, F_ACK, 4'(i), $sformatf("wrap_fetch%0d", i));
            chk(1'b0, 4'd7, 1'b0, 1'b0, 3'd1, JMP,   4'(i), $sformatf("wrap_jmp%0d", i));
        end
        chk(1'b0, 4'd0, 1'b0, 1'b0, 3'd0, IMEM, 4'd0, "wrap_zero");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
